// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and width helpers for the truth-table sequencer family.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package truth_table_pkg;

    // Sweep controller states.
    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        SAMPLE,
        DONE
    } state_e;

    // Settle counter width; covers settle windows of 0..15 cycles.
    localparam int SETTLE_W = 4;

    // Number of rows in the truth table of an n_in-input function.
    function automatic int table_w(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Bundle between a host/function block (master) and the sweep controller (slave).
// Latency: n/a (wires only).
// Backpressure: none; start is level-sensitive and only sampled while idle.
// Optional: TRUTH_TABLE_CHECK_EN adds expected/pass/mismatch_cnt.
interface truth_table_sequencer_if #(
    parameter int N_IN = 3
);
    import truth_table_pkg::*;

    localparam int TABLE_W = table_w(N_IN);

    logic                start;
    logic                abort;
    logic                f_in;
    logic [N_IN-1:0]     x_out;
    logic                busy;
    logic                done;
    logic [TABLE_W-1:0]  table_out;
`ifdef TRUTH_TABLE_CHECK_EN
    logic [TABLE_W-1:0]  expected;
    logic                pass;
    logic [N_IN:0]       mismatch_cnt;

    modport master (
        output start, abort, f_in, expected,
        input  x_out, busy, done, table_out, pass, mismatch_cnt
    );
    modport slave (
        input  start, abort, f_in, expected,
        output x_out, busy, done, table_out, pass, mismatch_cnt
    );
`else
    modport master (
        output start, abort, f_in,
        input  x_out, busy, done, table_out
    );
    modport slave (
        input  start, abort, f_in,
        output x_out, busy, done, table_out
    );
`endif

endinterface

// File: rtl/truth_table_sequencer_settle_timer.sv
// settle_timer: loadable down-counter; expire_o flags the last cycle of a window.
// Latency: load takes effect next cycle; expire_o is high while the count equals 1.
// Backpressure: none; en_i simply gates the decrement.
// Ports: clk, rst (async active-high), load_i/load_val_i, en_i, expire_o.
module settle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiring at 1 (not 0) makes a load of S give exactly S waiting cycles.
    assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps an N_IN-input function through all 2^N_IN vectors and captures f per vector.
// Latency: SETTLE+2 cycles per vector; done 2^N_IN*(SETTLE+2)+1 edges after start is taken.
// Backpressure: start ignored while busy; abort returns to idle without done.
// Ports: clk, rst (async active-high), bus (slave modport: start/abort/f_in in,
// x_out/busy/done/table_out out). Optional TRUTH_TABLE_CHECK_EN adds expected/pass/mismatch_cnt.
module truth_table_sequencer
    import truth_table_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    truth_table_sequencer_if.slave bus
);

    localparam int            TABLE_W = table_w(N_IN);
    localparam logic [N_IN:0] LAST    = (N_IN+1)'(TABLE_W - 1);

    state_e               state_q, state_d;
    logic [N_IN:0]        idx_q, idx_d;    // one spare bit: no wrap at the last vector
    logic [N_IN-1:0]      x_q, x_d;
    logic [TABLE_W-1:0]   tbl_q, tbl_d;
    logic                 done_q, done_d;
    logic                 tmr_load, tmr_en, tmr_expire;
    logic                 start_acc, sample_en;

    settle_timer #(.W(SETTLE_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (SETTLE_W'(SETTLE)),
        .en_i       (tmr_en),
        .expire_o   (tmr_expire)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        x_d       = x_q;
        tbl_d     = tbl_q;
        done_d    = 1'b0;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        start_acc = 1'b0;
        sample_en = 1'b0;
        case (state_q)
            IDLE: begin
                x_d = '0;
                // abort beats a simultaneous start
                if (bus.start && !bus.abort) begin
                    start_acc = 1'b1;
                    state_d   = DRIVE;
                    idx_d     = '0;
                    tbl_d     = '0;
                end
            end
            DRIVE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    x_d     = '0;
                end else begin
                    x_d      = idx_q[N_IN-1:0];
                    tmr_load = 1'b1;
                    state_d  = (SETTLE > 0) ? WAIT : SAMPLE;
                end
            end
            WAIT: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    x_d     = '0;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_expire) begin
                        state_d = SAMPLE;
                    end
                end
            end
            SAMPLE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    x_d     = '0;
                end else begin
                    sample_en                  = 1'b1;
                    tbl_d[idx_q[N_IN-1:0]]     = bus.f_in;
                    if (idx_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + (N_IN+1)'(1);
                        state_d = DRIVE;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                x_d     = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                x_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            x_q     <= '0;
            tbl_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            tbl_q   <= tbl_d;
            done_q  <= done_d;
        end
    end

    assign bus.x_out     = x_q;
    assign bus.busy      = (state_q == DRIVE) || (state_q == WAIT) || (state_q == SAMPLE);
    assign bus.done      = done_q;
    assign bus.table_out = tbl_q;

`ifdef TRUTH_TABLE_CHECK_EN
    logic [TABLE_W-1:0] exp_q;
    logic [N_IN:0]      mm_q;
    logic               pass_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q  <= '0;
            mm_q   <= '0;
            pass_q <= 1'b0;
        end else begin
            if (start_acc) begin
                exp_q  <= bus.expected;
                mm_q   <= '0;
                pass_q <= 1'b0;
            end else if (sample_en && (bus.f_in != exp_q[idx_q[N_IN-1:0]])) begin
                mm_q <= mm_q + (N_IN+1)'(1);
            end
            // Count is final while in DONE; pass lands together with done.
            if (state_q == DONE) begin
                pass_q <= (mm_q == '0);
            end
        end
    end

    assign bus.pass         = pass_q;
    assign bus.mismatch_cnt = mm_q;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
module tb_truth_table_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fault = 1'b0;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;
    int last_x = -1;
    int xs[$];
    int done_cnt0 = 0;
    int done_cnt1 = 0;

    always #5 clk = ~clk;

    truth_table_sequencer_if #(.N_IN(3)) if0 ();
    truth_table_sequencer_if #(.N_IN(3)) if1 ();

    // Function blocks: majority (optionally wrong at x=5) on unit 0, XOR3 on unit 1.
    assign if0.f_in = ((if0.x_out[0] & if0.x_out[1]) | (if0.x_out[0] & if0.x_out[2]) |
                       (if0.x_out[1] & if0.x_out[2])) ^ (fault && (if0.x_out == 3'd5));
    assign if1.f_in = ^if1.x_out;

    truth_table_sequencer #(.N_IN(3), .SETTLE(2)) u0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    truth_table_sequencer #(.N_IN(3), .SETTLE(0)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and look at the outputs 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
        if (if0.done) done_cnt0++;
        if (if1.done) done_cnt1++;
        if (if0.busy && (int'(if0.x_out) != last_x)) begin
            xs.push_back(int'(if0.x_out));
            last_x = int'(if0.x_out);
        end
    endtask

    // Edge 0 is the one that takes start.
    task automatic launch(input int which);
        if (which == 0) if0.start = 1'b1; else if1.start = 1'b1;
        xs.delete();
        last_x = -1;
        edge_n = -1;
        tick();
        if0.start = 1'b0;
        if1.start = 1'b0;
    endtask

    task automatic wait_done(input int which, input int limit);
        int k;
        k = 0;
        while ((k < limit) && !((which == 0) ? if0.done : if1.done)) begin
            tick();
            k++;
        end
    endtask

    function automatic logic [31:0] pack_xs();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < xs.size() && i < 8; i++) begin
            v = v | (32'(xs[i] & 15) << (4 * i));
        end
        return v;
    endfunction

    int d0;

    initial begin
        if0.start = 1'b0; if0.abort = 1'b0;
        if1.start = 1'b0; if1.abort = 1'b0;
`ifdef TRUTH_TABLE_CHECK_EN
        if0.expected = '0;
        if1.expected = '0;
`endif
        #12;
        check("rst_x_out",  64'(if0.x_out), 64'd0);
        check("rst_busy",   64'(if0.busy), 64'd0);
        check("rst_done",   64'(if0.done), 64'd0);
        check("rst_table",  64'(if0.table_out), 64'd0);
`ifdef TRUTH_TABLE_CHECK_EN
        check("rst_pass",   64'(if0.pass), 64'd0);
`endif
        rst = 1'b0;
        tick();
        tick();

        // Majority sweep, with an extra start pulse while busy.
        launch(0);
        repeat (9) tick();
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        check("maj_busy_mid", 64'(if0.busy), 64'd1);
        wait_done(0, 100);
        check("maj_done_edge", 64'(edge_n), 64'd33);
        check("maj_table", 64'(if0.table_out), 64'hE8);
        check("maj_x_count", 64'(xs.size()), 64'd8);
        check("maj_x_order", 64'(pack_xs()), 64'h76543210);
        check("maj_busy_at_done", 64'(if0.busy), 64'd0);
        check("maj_x_at_done", 64'(if0.x_out), 64'd0);
        tick();
        check("maj_done_width", 64'(if0.done), 64'd0);
        check("maj_table_hold", 64'(if0.table_out), 64'hE8);
        check("maj_idle_busy", 64'(if0.busy), 64'd0);

        // XOR3 with no settle window.
        launch(1);
        wait_done(1, 100);
        check("xor_done_edge", 64'(edge_n), 64'd17);
        check("xor_table", 64'(if1.table_out), 64'h96);
        tick();

        // abort and start together in idle: nothing starts.
        if0.start = 1'b1;
        if0.abort = 1'b1;
        tick();
        if0.start = 1'b0;
        if0.abort = 1'b0;
        check("abort_start_busy", 64'(if0.busy), 64'd0);
        tick();
        check("abort_start_busy2", 64'(if0.busy), 64'd0);

        // Abort during the WAIT of vector 4.
        launch(0);
        repeat (17) tick();
        check("pre_abort_x", 64'(if0.x_out), 64'd4);
        d0 = done_cnt0;
        if0.abort = 1'b1;
        tick();
        if0.abort = 1'b0;
        check("abort_x_out", 64'(if0.x_out), 64'd0);
        check("abort_busy", 64'(if0.busy), 64'd0);
        check("abort_table", 64'(if0.table_out), 64'h08);
        repeat (40) tick();
        check("abort_no_done", 64'(done_cnt0 - d0), 64'd0);
        launch(0);
        wait_done(0, 100);
        check("post_abort_edge", 64'(edge_n), 64'd33);
        check("post_abort_table", 64'(if0.table_out), 64'hE8);
        tick();

        // Asynchronous reset while sampling vector 5.
        launch(0);
        repeat (23) tick();
        check("pre_rst_x", 64'(if0.x_out), 64'd5);
        d0 = done_cnt0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_x", 64'(if0.x_out), 64'd0);
        check("mid_rst_busy", 64'(if0.busy), 64'd0);
        check("mid_rst_table", 64'(if0.table_out), 64'd0);
        check("mid_rst_done", 64'(if0.done), 64'd0);
        #3 rst = 1'b0;
        repeat (40) tick();
        check("rst_no_done", 64'(done_cnt0 - d0), 64'd0);
        launch(0);
        wait_done(0, 100);
        check("post_rst_edge", 64'(edge_n), 64'd33);
        check("post_rst_table", 64'(if0.table_out), 64'hE8);
        tick();

        // start held high: back-to-back sweeps, 34 edges apart.
        if0.start = 1'b1;
        xs.delete();
        last_x = -1;
        edge_n = -1;
        tick();
        wait_done(0, 100);
        check("held_done1", 64'(edge_n), 64'd33);
        tick();
        check("held_retrigger", 64'(if0.busy), 64'd1);
        wait_done(0, 100);
        check("held_done2", 64'(edge_n), 64'd67);
        check("held_table", 64'(if0.table_out), 64'hE8);
        if0.start = 1'b0;
        tick();
        check("held_stop", 64'(if0.busy), 64'd0);
        tick();

`ifdef TRUTH_TABLE_CHECK_EN
        // Wrong answer at x=5 against the majority reference.
        fault = 1'b1;
        if0.expected = 8'hE8;
        launch(0);
        if0.expected = 8'h00;   // latched at start; later changes must not matter
        wait_done(0, 100);
        check("chk_table", 64'(if0.table_out), 64'hC8);
        check("chk_mismatch", 64'(if0.mismatch_cnt), 64'd1);
        check("chk_pass_bad", 64'(if0.pass), 64'd0);
        tick();
        fault = 1'b0;
        if0.expected = 8'hE8;
        launch(0);
        wait_done(0, 100);
        check("chk_mismatch_clean", 64'(if0.mismatch_cnt), 64'd0);
        check("chk_pass_good", 64'(if0.pass), 64'd1);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
